// File: rtl/sap1_pkg.sv
// Shared constants for the SAP-1 microsequencer: widths, control-bit positions,
// opcodes, micro-routine entry points and the opcode-to-routine map.
package sap1_pkg;

  localparam int unsigned UPC_W = 5;
  localparam int unsigned CW_W  = 17;
  localparam int unsigned NT    = 6;

  // Control word bit positions, MSB to LSB
  localparam int unsigned EP_B   = 16;
  localparam int unsigned CP_B   = 15;
  localparam int unsigned LM_B   = 14;
  localparam int unsigned CE_B   = 13;
  localparam int unsigned LI_B   = 12;
  localparam int unsigned EI_B   = 11;
  localparam int unsigned CS_B   = 10;
  localparam int unsigned LOAD_B = 9;
  localparam int unsigned CLR_B  = 8;
  localparam int unsigned INC_B  = 7;
  localparam int unsigned LA_B   = 6;
  localparam int unsigned EA_B   = 5;
  localparam int unsigned LB_B   = 4;
  localparam int unsigned SU_B   = 3;
  localparam int unsigned AD_B   = 2;
  localparam int unsigned EU_B   = 1;
  localparam int unsigned LO_B   = 0;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam logic [UPC_W-1:0] FETCH_ADDR = 5'd0;
  localparam logic [UPC_W-1:0] LDA_ADDR   = 5'd3;
  localparam logic [UPC_W-1:0] ADD_ADDR   = 5'd6;
  localparam logic [UPC_W-1:0] SUB_ADDR   = 5'd9;
  localparam logic [UPC_W-1:0] OUT_ADDR   = 5'd12;
  localparam logic [UPC_W-1:0] NOP_ADDR   = 5'd15;
  localparam logic [UPC_W-1:0] HLT_ADDR   = 5'd18;

  // Undefined opcodes fall into the NOP routine so timing stays uniform
  function automatic logic [UPC_W-1:0] map_opcode(input logic [3:0] op);
    case (op)
      OP_LDA:  return LDA_ADDR;
      OP_ADD:  return ADD_ADDR;
      OP_SUB:  return SUB_ADDR;
      OP_OUT:  return OUT_ADDR;
      OP_HLT:  return HLT_ADDR;
      default: return NOP_ADDR;
    endcase
  endfunction

endpackage

// File: rtl/sap1_control_rom.sv
// Horizontal control store: combinational micro-PC to control-word lookup.
module sap1_control_rom
  import sap1_pkg::*;
(
  input  logic [UPC_W-1:0] upc,
  output logic [CW_W-1:0]  cw
);

  function automatic logic [CW_W-1:0] bit_of(input int unsigned idx);
    return CW_W'(1) << idx;
  endfunction

  always_comb begin
    cw = bit_of(CLR_B);
    case (upc)
      UPC_W'(0): cw = bit_of(EP_B) | bit_of(LM_B) | bit_of(CS_B) | bit_of(INC_B);
      UPC_W'(1): cw = bit_of(CP_B) | bit_of(CS_B) | bit_of(INC_B);
      UPC_W'(2): cw = bit_of(CE_B) | bit_of(LI_B) | bit_of(CS_B) | bit_of(LOAD_B);
      UPC_W'(3), UPC_W'(6), UPC_W'(9):
        cw = bit_of(EI_B) | bit_of(LM_B) | bit_of(INC_B);
      UPC_W'(4): cw = bit_of(CE_B) | bit_of(LA_B) | bit_of(INC_B);
      UPC_W'(7), UPC_W'(10):
        cw = bit_of(CE_B) | bit_of(LB_B) | bit_of(INC_B);
      UPC_W'(8):  cw = bit_of(AD_B) | bit_of(EU_B) | bit_of(LA_B) | bit_of(CLR_B);
      UPC_W'(11): cw = bit_of(SU_B) | bit_of(EU_B) | bit_of(LA_B) | bit_of(CLR_B);
      UPC_W'(12): cw = bit_of(EA_B) | bit_of(LO_B) | bit_of(INC_B);
      UPC_W'(13), UPC_W'(15), UPC_W'(16):
        cw = bit_of(INC_B);
      UPC_W'(5), UPC_W'(14), UPC_W'(17):
        cw = bit_of(CLR_B);
      UPC_W'(18): cw = '0;
      // Unused words steer back to fetch
      default:    cw = bit_of(CLR_B);
    endcase
  end

endmodule

// File: rtl/sap1_microsequencer.sv
// SAP-1 horizontal microsequencer: micro-PC, opcode mapping, T-state ring
// counter and halt tracking around the control store.
module sap1_microsequencer
  import sap1_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [3:0]       opcode,
  output logic [CW_W-1:0]  cw,
  output logic [UPC_W-1:0] upc,
  output logic [NT-1:0]    t_state,
  output logic             halted
);

  logic [UPC_W-1:0] upc_d;
  logic [NT-1:0]    t_d;
  logic             halted_d;
  logic [CW_W-1:0]  rom_cw;
  logic             advance;

  sap1_control_rom u_rom (
    .upc (upc),
    .cw  (rom_cw)
  );

  assign advance = run & ~halted;

  // Next micro-PC: CLR beats LOAD beats INC; CLR also realigns the ring
  always_comb begin
    upc_d    = upc;
    t_d      = t_state;
    halted_d = halted;
    if (advance) begin
      if (rom_cw[CLR_B]) begin
        upc_d = FETCH_ADDR;
        t_d   = NT'(1);
      end else begin
        if (rom_cw[LOAD_B]) begin
          upc_d = map_opcode(opcode);
        end else if (rom_cw[INC_B]) begin
          upc_d = upc + UPC_W'(1);
        end
        t_d = {t_state[NT-2:0], t_state[NT-1]};
      end
      halted_d = (upc_d == HLT_ADDR);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      upc     <= FETCH_ADDR;
      t_state <= NT'(1);
      halted  <= 1'b0;
    end else begin
      upc     <= upc_d;
      t_state <= t_d;
      halted  <= halted_d;
    end
  end

  assign cw = halted ? '0 : rom_cw;

endmodule
